secret_driver_chk: RTL and testbench

Self-checking stimulus/response engine for the opposite end of the protected `secret_impl` port set. It drives LFSR-generated stimulus into a `secret_impl` instance (plain or DPI-protected) and checks every response against a cycle-accurate shadow model:
- sequential accumulator;
- mixed bypass path;
- combinational pass-through lanes.

It sits beside the DUT in the protected-library regression and reports pass/fail plus an error count.

---
 rtl/secret_driver_chk_pkg.sv | 28 ++
 rtl/secret_driver_chk_if.sv | 43 ++++
 rtl/secret_driver_chk_lfsr.sv | 25 ++
 rtl/secret_driver_chk.sv | 152 +++++++++++++++
 tb/tb_secret_driver_chk.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/secret_driver_chk_pkg.sv
// Shared types and constants for the secret_impl stimulus/response checker.
// Contents: FSM state enum, LFSR polynomial, lane widths, accumulator width,
// and the single-step Galois LFSR function used by secret_lfsr.
package secret_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } drv_state_e;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned W1     = 1;
    localparam int unsigned W8     = 8;
    localparam int unsigned W33    = 33;
    localparam int unsigned W65    = 65;
    localparam int unsigned W129   = 129;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Right-shifting Galois step: the bit shifted out selects the polynomial.
    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/secret_driver_chk_if.sv
// Port bundle between secret_driver_chk and a secret_impl instance.
// master: the checker (drives stimulus, receives responses).
// slave:  the secret_impl side (receives stimulus, drives responses).
// Wide lanes (65/129 bits) exist only when SECRET_DRV_WIDE_EN is defined.
interface secret_driver_chk_if;
    import secret_drv_pkg::*;

    logic [ACC_W-1:0] accum_in;
    logic             accum_bypass;
    logic [ACC_W-1:0] accum_out;
    logic [ACC_W-1:0] accum_bypass_out;
    logic [W1-1:0]    s1_in;
    logic [W1-1:0]    s1_out;
    logic [W8-1:0]    s8_in;
    logic [W8-1:0]    s8_out;
    logic [W33-1:0]   s33_in;
    logic [W33-1:0]   s33_out;
`ifdef SECRET_DRV_WIDE_EN
    logic [W65-1:0]   s65_in;
    logic [W65-1:0]   s65_out;
    logic [W129-1:0]  s129_in;
    logic [W129-1:0]  s129_out;
`endif

    modport master (
        output accum_in, accum_bypass, s1_in, s8_in, s33_in,
`ifdef SECRET_DRV_WIDE_EN
        output s65_in, s129_in,
        input  s65_out, s129_out,
`endif
        input  accum_out, accum_bypass_out, s1_out, s8_out, s33_out
    );

    modport slave (
        input  accum_in, accum_bypass, s1_in, s8_in, s33_in,
`ifdef SECRET_DRV_WIDE_EN
        input  s65_in, s129_in,
        output s65_out, s129_out,
`endif
        output accum_out, accum_bypass_out, s1_out, s8_out, s33_out
    );

endinterface

// File: rtl/secret_driver_chk_lfsr.sv
// 32-bit Galois LFSR stimulus source.
// Ports: clk, rst (sync active-high, loads SEED; SEED==0 loads 1),
//        adv (advance one step), q (current state).
module secret_lfsr
    import secret_drv_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [31:0] q
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED_EFF;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/secret_driver_chk.sv
// Stimulus/response checker for the secret_impl port set. Drives LFSR
// stimulus for NUM_CYCLES RUN cycles, checks the accumulator, bypass path
// and pass-through lanes against a shadow model, then one DRAIN cycle.
// Ports: clk, rst (sync active-high), start (honoured in IDLE/DONE),
//        bus (secret_driver_chk_if.master), busy, done, pass,
//        err_count (saturating), first_err_cycle.
// Build option: SECRET_DRV_WIDE_EN adds the 65/129-bit lanes.
module secret_driver_chk
    import secret_drv_pkg::*;
#(
    parameter int unsigned NUM_CYCLES    = 64,
    parameter logic [31:0] SEED          = 32'h1,
    parameter int unsigned BYPASS_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    secret_driver_chk_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      first_err_cycle
);

    drv_state_e       state, state_nxt;
    logic [31:0]      lfsr_q;
    logic [ACC_W-1:0] shadow;
    logic [CNT_W-1:0] cyc;
    logic [31:0]      ph;
    logic             go, last, checking, mis;
    logic             stim_load, stim_clr, byp_val;
    logic [31:0]      ph_nxt;

    assign go        = start && (state == ST_IDLE || state == ST_DONE);
    assign last      = (cyc == CNT_W'(NUM_CYCLES - 1));
    assign checking  = (state == ST_RUN) || (state == ST_DRAIN);
    assign stim_load = go || (state == ST_RUN && !last);
    assign stim_clr  = (state == ST_RUN) && last;

    secret_lfsr #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (go || state == ST_RUN),
        .q   (lfsr_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (last)  state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = (state == ST_RUN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_count == '0);
    end

    // ph holds (index of the next cycle to drive) mod BYPASS_PERIOD, so the
    // bypass strobe needs no divider. On a start edge index 0 is driven.
    always_comb begin
        if (go) begin
            byp_val = (BYPASS_PERIOD == 1);
            ph_nxt  = (BYPASS_PERIOD == 1) ? 32'd0 : 32'd1;
        end else begin
            byp_val = (ph == 32'(BYPASS_PERIOD - 1));
            ph_nxt  = byp_val ? 32'd0 : ph + 32'd1;
        end
    end

    // Combined check; in DRAIN the stimulus is all zero, so the same
    // compare covers the drain expectations.
    always_comb begin
        mis = (bus.accum_out != shadow)
            || (bus.accum_bypass_out != (bus.accum_bypass ? bus.accum_in : shadow))
            || (bus.s1_out != bus.s1_in)
            || (bus.s8_out != bus.s8_in)
            || (bus.s33_out != bus.s33_in);
`ifdef SECRET_DRV_WIDE_EN
        mis = mis
            || (bus.s65_out != bus.s65_in)
            || (bus.s129_out != bus.s129_in);
`endif
    end

    // Registered stimulus
    always_ff @(posedge clk) begin
        if (rst || stim_clr) begin
            bus.accum_in     <= '0;
            bus.accum_bypass <= 1'b0;
            bus.s1_in        <= '0;
            bus.s8_in        <= '0;
            bus.s33_in       <= '0;
`ifdef SECRET_DRV_WIDE_EN
            bus.s65_in       <= '0;
            bus.s129_in      <= '0;
`endif
            ph               <= '0;
        end else if (stim_load) begin
            bus.accum_in     <= lfsr_q;
            bus.accum_bypass <= byp_val;
            bus.s1_in        <= lfsr_q[0];
            bus.s8_in        <= lfsr_q[7:0];
            bus.s33_in       <= {lfsr_q[0], lfsr_q};
`ifdef SECRET_DRV_WIDE_EN
            bus.s65_in       <= {lfsr_q[0], lfsr_q, ~lfsr_q};
            bus.s129_in      <= {lfsr_q[0], lfsr_q, ~lfsr_q, lfsr_q, ~lfsr_q};
`endif
            ph               <= ph_nxt;
        end
    end

    // Shadow model, cycle counter and error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow          <= '0;
            cyc             <= '0;
            err_count       <= '0;
            first_err_cycle <= '0;
        end else if (go) begin
            // DUT accumulator has no reset: adopt its current value.
            shadow          <= bus.accum_out;
            cyc             <= '0;
            err_count       <= '0;
            first_err_cycle <= '0;
        end else begin
            if (state == ST_RUN) begin
                shadow <= shadow + bus.accum_in;
                cyc    <= cyc + 1'b1;
            end
            if (checking && mis) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_cycle <= cyc;
            end
        end
    end

endmodule

// File: tb/tb_secret_driver_chk.sv
module tb_secret_driver_chk;
    import secret_drv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1, start2, clr, link0, flip8;

    secret_driver_chk_if b0 ();
    secret_driver_chk_if b1 ();
    secret_driver_chk_if b2 ();

    logic        busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] err0, fst0, err1, fst1, err2, fst2;

    secret_driver_chk #(.NUM_CYCLES(64), .SEED(32'h1), .BYPASS_PERIOD(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .bus(b0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .first_err_cycle(fst0));
    secret_driver_chk #(.NUM_CYCLES(1000), .SEED(32'hFFFF_FFFF), .BYPASS_PERIOD(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .bus(b1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .first_err_cycle(fst1));
    secret_driver_chk #(.NUM_CYCLES(16), .SEED(32'h1), .BYPASS_PERIOD(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .bus(b2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .first_err_cycle(fst2));

    // Behavioural secret_impl models (accumulator without reset, 1-cycle latency)
    logic [31:0] acc0, acc1, acc2, m0_in;
    assign m0_in = link0 ? b0.accum_in : 32'd3;
    always @(posedge clk) begin
        acc0 <= clr ? 32'd0 : acc0 + m0_in;
        acc1 <= clr ? 32'd0 : acc1 + b1.accum_in;
        acc2 <= clr ? 32'd0 : acc2 + b2.accum_in;
    end

    assign b0.accum_out        = acc0;
    assign b0.accum_bypass_out = b0.accum_bypass ? m0_in : acc0;
    assign b0.s1_out           = b0.s1_in;
    assign b0.s8_out           = b0.s8_in ^ {7'd0, flip8};
    assign b0.s33_out          = b0.s33_in;
    assign b1.accum_out        = acc1;
    assign b1.accum_bypass_out = b1.accum_bypass ? b1.accum_in : acc1;
    assign b1.s1_out           = b1.s1_in;
    assign b1.s8_out           = b1.s8_in;
    assign b1.s33_out          = b1.s33_in;
    assign b2.accum_out        = acc2;
    assign b2.accum_bypass_out = acc2;   // broken bypass path
    assign b2.s1_out           = b2.s1_in;
    assign b2.s8_out           = b2.s8_in;
    assign b2.s33_out          = b2.s33_in;
`ifdef SECRET_DRV_WIDE_EN
    assign b0.s65_out  = b0.s65_in;
    assign b0.s129_out = b0.s129_in;
    assign b1.s65_out  = b1.s65_in;
    assign b1.s129_out = b1.s129_in;
    assign b2.s65_out  = b2.s65_in;
    assign b2.s129_out = b2.s129_in;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic done_of(input int id);
        case (id)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Pulse start across one rising edge; returns in RUN cycle 0.
    task automatic pulse(input int id);
        @(negedge clk);
        if (id == 0) start0 = 1'b1;
        else if (id == 1) start1 = 1'b1;
        else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input int id, input int limit);
        int n = 0;
        while (!done_of(id) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_reached_u%0d", id), 64'(done_of(id)), 64'd1);
    endtask

    typedef struct {
        int          c;
        logic [31:0] ain;
        logic        byp;
        logic        s1;
        logic [7:0]  s8;
        logic [32:0] s33;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur;
        // Seed 1 sequence: 1, 80200003, C0300002, 60180001, B02C0003, D8360002
        tbl[0] = '{0,  32'h0000_0001, 1'b0, 1'b1, 8'h01, 33'h1_0000_0001, 1'b1, 1'b0};
        tbl[1] = '{1,  32'h8020_0003, 1'b0, 1'b1, 8'h03, 33'h1_8020_0003, 1'b1, 1'b0};
        tbl[2] = '{2,  32'hC030_0002, 1'b0, 1'b0, 8'h02, 33'h0_C030_0002, 1'b1, 1'b0};
        tbl[3] = '{3,  32'h6018_0001, 1'b1, 1'b1, 8'h01, 33'h1_6018_0001, 1'b1, 1'b0};
        tbl[4] = '{4,  32'hB02C_0003, 1'b0, 1'b1, 8'h03, 33'h1_B02C_0003, 1'b1, 1'b0};
        tbl[5] = '{5,  32'hD836_0002, 1'b0, 1'b0, 8'h02, 33'h0_D836_0002, 1'b1, 1'b0};
        tbl[6] = '{64, 32'h0,         1'b0, 1'b0, 8'h00, 33'h0,           1'b1, 1'b0};
        tbl[7] = '{65, 32'h0,         1'b0, 1'b0, 8'h00, 33'h0,           1'b0, 1'b1};

        rst = 1'b1; clr = 1'b1; link0 = 1'b1; flip8 = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",   64'(busy0), 64'd0);
        chk("rst_done",   64'(done0), 64'd0);
        chk("rst_pass",   64'(pass0), 64'd0);
        chk("rst_err",    64'(err0),  64'd0);
        chk("rst_first",  64'(fst0),  64'd0);
        chk("rst_ain",    64'(b0.accum_in), 64'd0);
        chk("rst_byp",    64'(b0.accum_bypass), 64'd0);
        chk("rst_s33",    64'(b0.s33_in), 64'd0);
        rst = 1'b0; clr = 1'b0;

        // Clean run, defaults: stimulus vectors and drain/done timing
        pulse(0);
        cur = 0;
        for (int i = 0; i < 8; i++) begin
            while (cur < tbl[i].c) begin
                @(negedge clk);
                cur++;
            end
            chk($sformatf("c%0d_ain", tbl[i].c),  64'(b0.accum_in),     64'(tbl[i].ain));
            chk($sformatf("c%0d_byp", tbl[i].c),  64'(b0.accum_bypass), 64'(tbl[i].byp));
            chk($sformatf("c%0d_s1", tbl[i].c),   64'(b0.s1_in),        64'(tbl[i].s1));
            chk($sformatf("c%0d_s8", tbl[i].c),   64'(b0.s8_in),        64'(tbl[i].s8));
            chk($sformatf("c%0d_s33", tbl[i].c),  64'(b0.s33_in),       64'(tbl[i].s33));
            chk($sformatf("c%0d_busy", tbl[i].c), 64'(busy0),           64'(tbl[i].busy));
            chk($sformatf("c%0d_done", tbl[i].c), 64'(done0),           64'(tbl[i].done));
        end
        chk("clean_pass", 64'(pass0), 64'd1);
        chk("clean_err",  64'(err0),  64'd0);

        // Baseline capture: DUT pre-accumulates 5 x 3 = 15
        link0 = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        link0 = 1'b1;
        pulse(0);
        wait_done(0, 80);
        chk("base_pass", 64'(pass0), 64'd1);
        chk("base_err",  64'(err0),  64'd0);

        // Fault injection on s8_out bit 0 during RUN cycle 10
        pulse(0);
        repeat (10) @(negedge clk);
        chk("pre_fault_err", 64'(err0), 64'd0);
        flip8 = 1'b1;
        @(negedge clk);
        flip8 = 1'b0;
        chk("post_fault_err", 64'(err0), 64'd1);
        wait_done(0, 80);
        chk("fault_err",   64'(err0),  64'd1);
        chk("fault_first", 64'(fst0),  64'd10);
        chk("fault_pass",  64'(pass0), 64'd0);

        // Reset mid-run at RUN cycle 20
        pulse(0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy",  64'(busy0), 64'd0);
        chk("mid_done",  64'(done0), 64'd0);
        chk("mid_ain",   64'(b0.accum_in), 64'd0);
        chk("mid_s8",    64'(b0.s8_in), 64'd0);
        chk("mid_err",   64'(err0), 64'd0);
        rst = 1'b0;
        pulse(0);
        wait_done(0, 80);
        chk("mid_rerun_pass", 64'(pass0), 64'd1);

        // Wrap-around: long run with all-ones seed
        pulse(1);
        wait_done(1, 1100);
        chk("wrap_pass", 64'(pass1), 64'd1);
        chk("wrap_err",  64'(err1),  64'd0);

        // Broken bypass path with bypass every cycle
        pulse(2);
        wait_done(2, 40);
        chk("byp_err",   64'(err2),  64'd16);
        chk("byp_first", 64'(fst2),  64'd0);
        chk("byp_pass",  64'(pass2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
